// File: rtl/preg_ready_table_pkg.sv
// Shared types and helpers for the physical-register ready table and its neighbours.
// Holds the preg/wake types and a popcount helper that other occupancy counters reuse.
package preg_ready_table_pkg;

   localparam int FETCH_WIDTH  = 2;
   localparam int ALU_WAKE_NUM = 2;
   localparam int PREG_NUM     = 32;
   localparam int PREG_W       = $clog2(PREG_NUM);
   localparam int BUSY_W       = PREG_W + 1;

   typedef logic [PREG_W-1:0] preg_addr_t;

   typedef struct packed {
      logic       valid;
      preg_addr_t preg;
   } wake_req_t;

   // Width of the result leaves room for the all-ones case (PREG_NUM itself).
   function automatic logic [BUSY_W-1:0] popcount(input logic [PREG_NUM-1:0] vec);
      logic [BUSY_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < PREG_NUM; i++) begin
         cnt = cnt + BUSY_W'(vec[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/preg_ready_table_if.sv
// Query interface between the issue queue (master) and the ready table (slave).
// There is no valid/ready handshake: every query is answered combinationally in the same cycle.
interface ready_intf;
   import preg_ready_table_pkg::*;

   preg_addr_t [FETCH_WIDTH-1:0] psrc1;
   preg_addr_t [FETCH_WIDTH-1:0] psrc2;
   logic       [FETCH_WIDTH-1:0] v1;
   logic       [FETCH_WIDTH-1:0] v2;

   modport master (output psrc1, output psrc2, input v1, input v2);
   modport slave  (input psrc1, input psrc2, output v1, output v2);

endinterface

// File: rtl/preg_ready_table.sv
// One ready bit per physical register: rename clears it, ALU wakeups set it, branch_miss sets all.
// Queries see same-cycle wakes but not same-cycle allocs, since allocs belong to younger instructions.
module preg_ready_table
   import preg_ready_table_pkg::*;
(
   input  logic                           clk,
   input  logic                           reset,
   ready_intf.slave                       rdyIf,
   input  logic       [FETCH_WIDTH-1:0]   alloc_valid,
   input  preg_addr_t [FETCH_WIDTH-1:0]   alloc_preg,
   input  wake_req_t  [ALU_WAKE_NUM-1:0]  wake,
   input  logic                           branch_miss,
   output logic       [BUSY_W-1:0]        busy_cnt
);

   logic [PREG_NUM-1:0]    rdy;
   logic [PREG_NUM-1:0]    rdyNext;
   logic [BUSY_W-1:0]      busyCnt;
   logic [FETCH_WIDTH-1:0] qv1;
   logic [FETCH_WIDTH-1:0] qv2;

   always_comb begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         qv1[i] = rdy[rdyIf.psrc1[i]];
         qv2[i] = rdy[rdyIf.psrc2[i]];
         for (int k = 0; k < ALU_WAKE_NUM; k++) begin
            if (wake[k].valid && (wake[k].preg == rdyIf.psrc1[i])) qv1[i] = 1'b1;
            if (wake[k].valid && (wake[k].preg == rdyIf.psrc2[i])) qv2[i] = 1'b1;
         end
      end
   end

   assign rdyIf.v1 = qv1;
   assign rdyIf.v2 = qv2;

   // Later assignments win: allocs override wakes, branch_miss overrides everything.
   always_comb begin
      rdyNext = rdy;
      for (int k = 0; k < ALU_WAKE_NUM; k++) begin
         if (wake[k].valid) rdyNext[wake[k].preg] = 1'b1;
      end
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (alloc_valid[i]) rdyNext[alloc_preg[i]] = 1'b0;
      end
      if (branch_miss) rdyNext = '1;
   end

   // The count is recomputed from the next vector so redundant events cannot make it drift.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdy     <= '1;
         busyCnt <= '0;
      end else begin
         rdy     <= rdyNext;
         busyCnt <= popcount(~rdyNext);
      end
   end

   assign busy_cnt = busyCnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < FETCH_WIDTH; i++) begin
            for (int j = i + 1; j < FETCH_WIDTH; j++) begin
               if (alloc_valid[i] && alloc_valid[j]) assert (alloc_preg[i] != alloc_preg[j]);
            end
         end
      end
   end

endmodule

// File: tb/tb_preg_ready_table.sv
// Directed scenarios followed by a randomized run, checked against an array-based ready model.
module tb_preg_ready_table;
  import preg_ready_table_pkg::*;

  logic clk;
  logic reset;
  logic [FETCH_WIDTH-1:0] alloc_valid;
  preg_addr_t [FETCH_WIDTH-1:0] alloc_preg;
  wake_req_t [ALU_WAKE_NUM-1:0] wake;
  logic branch_miss;
  logic [BUSY_W-1:0] busy_cnt;

  ready_intf rif ();

  preg_ready_table dut (
    .clk         (clk),
    .reset       (reset),
    .rdyIf       (rif.slave),
    .alloc_valid (alloc_valid),
    .alloc_preg  (alloc_preg),
    .wake        (wake),
    .branch_miss (branch_miss),
    .busy_cnt    (busy_cnt)
  );

  int checks = 0;
  int errors = 0;
  bit mdl_rdy [PREG_NUM];

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit exp_ready(input preg_addr_t p);
    bit r;
    r = mdl_rdy[int'(p)];
    for (int k = 0; k < ALU_WAKE_NUM; k++) begin
      if (wake[k].valid && wake[k].preg == p) r = 1'b1;
    end
    return r;
  endfunction

  function automatic int exp_busy();
    int n;
    n = 0;
    for (int p = 0; p < PREG_NUM; p++) if (!mdl_rdy[p]) n++;
    return n;
  endfunction

  // Reference: apply the priority rules reset > branch_miss > alloc > wake directly.
  task automatic model_update();
    bit nxt [PREG_NUM];
    for (int p = 0; p < PREG_NUM; p++) begin
      nxt[p] = mdl_rdy[p];
      for (int k = 0; k < ALU_WAKE_NUM; k++)
        if (wake[k].valid && int'(wake[k].preg) == p) nxt[p] = 1'b1;
      for (int i = 0; i < FETCH_WIDTH; i++)
        if (alloc_valid[i] && int'(alloc_preg[i]) == p) nxt[p] = 1'b0;
      if (branch_miss || reset) nxt[p] = 1'b1;
    end
    mdl_rdy = nxt;
  endtask

  // driver tasks
  task automatic clear_inputs();
    reset = 1'b0;
    branch_miss = 1'b0;
    alloc_valid = '0;
    alloc_preg = '0;
    wake = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    clear_inputs();
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_query(input string tag);
    logic [FETCH_WIDTH-1:0] e1, e2;
    #1;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      e1[i] = exp_ready(rif.psrc1[i]);
      e2[i] = exp_ready(rif.psrc2[i]);
    end
    checks++;
    assert (rif.v1 === e1) else begin
      errors++;
      $error("FAIL %s_v1 observed=%b expected=%b", tag, rif.v1, e1);
    end
    checks++;
    assert (rif.v2 === e2) else begin
      errors++;
      $error("FAIL %s_v2 observed=%b expected=%b", tag, rif.v2, e2);
    end
  endtask

  task automatic check_busy(input string tag);
    check_val(tag, int'(busy_cnt), exp_busy());
  endtask

  task automatic set_query(input int a0, input int a1, input int b0, input int b1);
    rif.psrc1[0] = preg_addr_t'(a0);
    rif.psrc1[1] = preg_addr_t'(a1);
    rif.psrc2[0] = preg_addr_t'(b0);
    rif.psrc2[1] = preg_addr_t'(b1);
  endtask

  initial begin
    for (int p = 0; p < PREG_NUM; p++) mdl_rdy[p] = 1'b1;
    clear_inputs();
    set_query(0, 0, 0, 0);
    reset = 1'b1;
    step();
    step();

    // 1: after reset everything reads ready
    set_query(0, 5, 31, 1);
    #1;
    check_val("rst_v1", int'(rif.v1), 3);
    check_val("rst_busy", int'(busy_cnt), 0);
    check_query("rst_q");

    // 2: alloc 7 and 9
    alloc_valid = 2'b11;
    alloc_preg[0] = 5'd7;
    alloc_preg[1] = 5'd9;
    step();
    set_query(7, 9, 7, 8);
    #1;
    check_val("alloc_v1", int'(rif.v1), 0);
    check_val("alloc_busy", int'(busy_cnt), 2);
    check_query("alloc_q");

    // 3: wake 7 bypasses into a same-cycle query
    wake[0] = '{valid: 1'b1, preg: 5'd7};
    set_query(7, 9, 9, 7);
    #1;
    check_val("bypass_v1_0", int'(rif.v1[0]), 1);
    check_query("bypass_q");
    step();
    check_val("wake_busy", int'(busy_cnt), 1);
    set_query(7, 9, 9, 7);
    check_query("wake_q");

    // 4: alloc and wake of the same preg: alloc wins
    alloc_valid = 2'b01;
    alloc_preg[0] = 5'd12;
    wake[1] = '{valid: 1'b1, preg: 5'd12};
    step();
    set_query(12, 9, 12, 0);
    #1;
    check_val("allocwins_v1", int'(rif.v1), 0);
    check_val("allocwins_busy", int'(busy_cnt), 2);
    check_query("allocwins_q");

    // 5: branch_miss beats an alloc and clears everything
    alloc_valid = 2'b11;
    alloc_preg[0] = 5'd3;
    alloc_preg[1] = 5'd4;
    step();
    check_val("pre_bm_busy", int'(busy_cnt), 4);
    branch_miss = 1'b1;
    alloc_valid = 2'b01;
    alloc_preg[0] = 5'd20;
    step();
    set_query(3, 4, 9, 20);
    #1;
    check_val("bm_v1", int'(rif.v1), 3);
    check_val("bm_v2", int'(rif.v2), 3);
    check_val("bm_busy", int'(busy_cnt), 0);

    // 6: fill the whole table, then reset in the middle of more allocs
    for (int c = 0; c < PREG_NUM / 2; c++) begin
      alloc_valid = 2'b11;
      alloc_preg[0] = preg_addr_t'(2 * c);
      alloc_preg[1] = preg_addr_t'(2 * c + 1);
      step();
    end
    check_val("full_busy", int'(busy_cnt), PREG_NUM);
    set_query(0, 31, 16, 17);
    check_query("full_q");
    reset = 1'b1;
    alloc_valid = 2'b11;
    alloc_preg[0] = 5'd1;
    alloc_preg[1] = 5'd2;
    wake[0] = '{valid: 1'b1, preg: 5'd5};
    step();
    #1;
    check_val("midrst_busy", int'(busy_cnt), 0);
    check_val("midrst_v1", int'(rif.v1), 3);
    check_val("midrst_v2", int'(rif.v2), 3);

    // randomized run
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        alloc_valid[i] = ($urandom_range(0, 99) < 45);
        alloc_preg[i] = preg_addr_t'($urandom);
      end
      if (alloc_preg[1] == alloc_preg[0]) alloc_preg[1] = alloc_preg[0] + 1'b1;
      for (int k = 0; k < ALU_WAKE_NUM; k++) begin
        wake[k].valid = ($urandom_range(0, 99) < 60);
        wake[k].preg = preg_addr_t'($urandom);
      end
      branch_miss = ($urandom_range(0, 63) == 0);
      reset = ($urandom_range(0, 199) == 0);
      set_query($urandom, $urandom, $urandom, $urandom);
      check_query("rand_q");
      step();
      check_busy("rand_busy");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
